instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Hardware instruction issuer for the lab3 datapath: holds a small program of 11-bit
//  instructions and drives instr/exec into the control state machine, replacing bench-driven
//  stimulus. Sits between the board-level controls and the SM; the SM responds, this block initiates.
//  Exec hold time is derived from the opcode, so the SM needs no handshake output.
// PARAMETERS
//  DEPTH   16  program memory entries
//  ADDR_W  4   program address width; DEPTH <= 2**ADDR_W
//  INSTR_W 11  instruction width, fields [0:2] op, [3:4] rx, [5:6] ry, [7:10] imm
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  prog_we    in   1        program write strobe; ignored while busy
//  prog_addr  in   ADDR_W   program write address
//  prog_data  in   INSTR_W  program write data
//  prog_len   in   ADDR_W+1 instruction count, 0..DEPTH; sampled on accepted start
//  start      in   1        begin execution at pc=0; ignored unless IDLE
//  stop       in   1        abort after current instruction completes
//  exec       out  1        execute strobe to SM
//  instr      out  [0:INSTR_W-1] instruction to SM, stable while exec=1
//  pc         out  ADDR_W   address of current/last issued instruction
//  busy       out  1        high from accepted start until DONE
//  done       out  1        one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async, immediate): exec=0, instr=0, pc=0, busy=0, done=0, FSM=IDLE; memory not cleared.
//    Reset mid-instruction drops exec at once; no partial-instruction completion.
//  - FSM: IDLE -> ISSUE -> GAP -> (ISSUE | DONE) ; DONE -> IDLE.
//  - IDLE: start=1 at edge latches prog_len; len=0 -> DONE next cycle; else ISSUE, pc=0,
//    instr=mem[0], exec=1, busy=1 on the following cycle.
//  - ISSUE: exec=1 for HOLD cycles; HOLD=3 for op 000 (load) and 100 (disp), HOLD=5 for all
//    other ops. Down-counter loaded on ISSUE entry; instr constant for the whole hold.
//  - GAP: exactly 1 cycle exec=0, instr held. Then if stop seen during this instr, or
//    pc==len-1 -> DONE; else pc=pc+1, ISSUE with instr=mem[pc+1].
//  - DONE: done=1, busy=0, exec=0 for one cycle; -> IDLE. pc keeps last issued address.
//  - stop: sticky flag set in ISSUE/GAP, cleared in IDLE; never truncates an exec hold.
//  - prog_we: write occurs at edge only when FSM=IDLE or DONE; dropped otherwise.
//  - prog_len > DEPTH clamps to DEPTH. pc increment wraps modulo 2**ADDR_W.
//  - Simultaneous start and prog_we in IDLE: write and start both taken; the write is
//    visible to the fetch (write-first) if prog_addr==0.
// CONFIGURATION
//  SEQ_LOOP_EN defined: at pc==len-1 in GAP (without stop) pc wraps to 0 and ISSUE
//    continues indefinitely; done pulses only on stop-terminated runs. busy stays high.
//  SEQ_LOOP_EN undefined: run ends after the last instruction as above; stop still honoured.
// TESTING
//  1 Assert rst_n=0 mid-ISSUE -> exec, busy, done, pc, instr all 0 in the same cycle.
//  2 Program 4 loads (00000000001,00001000010,00010000100,00011001000), len=4, start ->
//    each exec high 3 cycles, 1-cycle gap, done pulses once; SM leaves r0..r3=1,2,4,8.
//  3 Program mov r2,r3 / add r2,r1 / sub r3,r0 / addi r3,8 / subi r3,5 / disp r3 after
//    test 2 -> exec hold 5,5,5,5,5,3 cycles; final r2=10, r3=10.
//  4 len=0, start -> done high exactly 1 cycle after start, exec never asserted, busy stays 0.
//  5 Assert stop during 2nd instr of a 4-instr run; pulse start and prog_we while busy ->
//    2nd instr keeps full hold, done follows its gap, pc=1; start/write have no effect.
//  6 SEQ_LOOP_EN, len=2 -> instr sequence mem[0],mem[1],mem[0],... until stop; then done once.

Source files
------------

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Issues a stored program of instructions to the control SM with
//            opcode-derived exec hold times. Build option: SEQ_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int INSTR_W = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [0:INSTR_W-1] prog_data,
   input  logic [ADDR_W:0]    prog_len,
   input  logic               start,
   input  logic               stop,
   output logic               exec,
   output logic [0:INSTR_W-1] instr,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_PC_ZERO = '0;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [0:INSTR_W-1] instr_q, instr_d;
   logic [ADDR_W:0]    len_q, len_d;
   logic [2:0]         cnt_q, cnt_d;
   logic               stop_q, stop_d;
   logic [0:INSTR_W-1] mem_q [DEPTH];

   logic               prog_wr_en;
   logic [0:INSTR_W-1] fetch_first;
   logic [ADDR_W-1:0]  pc_inc;
   logic               last_instr;

   // Counter holds (cycles - 1): load and disp get 3 cycles, everything else 5.
   function automatic logic [2:0] hold_init(input logic [0:INSTR_W-1] w);
      logic [2:0] op;
      op = w[0:2];
      return (op == 3'b000 || op == 3'b100) ? 3'd2 : 3'd4;
   endfunction

   assign prog_wr_en  = prog_we && (state_q == S_IDLE || state_q == S_DONE)
                        && ({1'b0, prog_addr} < c_DEPTH);
   // Write-first bypass so a same-edge write to entry 0 is what gets issued.
   assign fetch_first = (prog_wr_en && prog_addr == c_PC_ZERO) ? prog_data : mem_q[c_PC_ZERO];
   assign pc_inc      = pc_q + 1'b1;
   assign last_instr  = ({1'b0, pc_q} == (len_q - 1'b1));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      stop_d  = stop_q;
      case (state_q)
         S_IDLE: begin
            stop_d = 1'b0;
            if (start) begin
               len_d = (prog_len > c_DEPTH) ? c_DEPTH : prog_len;
               if (prog_len == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
                  pc_d    = c_PC_ZERO;
                  instr_d = fetch_first;
                  cnt_d   = hold_init(fetch_first);
               end
            end
         end
         S_ISSUE: begin
            stop_d = stop_q | stop;
            if (cnt_q == 3'd0) state_d = S_GAP;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_GAP: begin
            stop_d = stop_q | stop;
            if (stop_q || stop) begin
               state_d = S_DONE;
            end else if (last_instr) begin
`ifdef SEQ_LOOP_EN
               state_d = S_ISSUE;
               pc_d    = c_PC_ZERO;
               instr_d = mem_q[c_PC_ZERO];
               cnt_d   = hold_init(mem_q[c_PC_ZERO]);
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_ISSUE;
               pc_d    = pc_inc;
               instr_d = mem_q[pc_inc];
               cnt_d   = hold_init(mem_q[pc_inc]);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         stop_q  <= stop_d;
      end
   end

   // Program store is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (prog_wr_en) mem_q[prog_addr] <= prog_data;
   end

   assign exec  = (state_q == S_ISSUE);
   assign busy  = (state_q == S_ISSUE) || (state_q == S_GAP);
   assign done  = (state_q == S_DONE);
   assign instr = instr_q;
   assign pc    = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Brief    : Self-checking bench for instr_sequencer against a cycle-trace model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;
   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;
   localparam int INSTR_W = 11;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               prog_we = 1'b0;
   logic [ADDR_W-1:0]  prog_addr = '0;
   logic [0:INSTR_W-1] prog_data = '0;
   logic [ADDR_W:0]    prog_len = '0;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic               exec;
   logic [0:INSTR_W-1] instr;
   logic [ADDR_W-1:0]  pc;
   logic               busy;
   logic               done;

   instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
      .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len), .start(start), .stop(stop),
      .exec(exec), .instr(instr), .pc(pc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic               ex;
      logic               bz;
      logic               dn;
      logic [0:INSTR_W-1] ins;
      logic [ADDR_W-1:0]  p;
   } rec_t;

   int                 checks = 0;
   int                 errors = 0;
   logic [0:INSTR_W-1] mem_m [DEPTH];
   logic [0:INSTR_W-1] last_instr_m = '0;
   logic [ADDR_W-1:0]  last_pc_m = '0;
   rec_t               exp_q[$];
   int                 ord_q[$];
   logic [7:0]         r [4];
   logic               exec_prev = 1'b0;

   function automatic int hold_of(input logic [0:INSTR_W-1] w);
      return (w[0:2] == 3'd0 || w[0:2] == 3'd4) ? 3 : 5;
   endfunction

   // Behaviour of the downstream SM, used to judge end-to-end program effects.
   task automatic sm_exec(input logic [0:INSTR_W-1] w);
      logic [2:0] op;
      logic [1:0] rx, ry;
      logic [7:0] imm;
      op = w[0:2]; rx = w[3:4]; ry = w[5:6]; imm = {4'd0, w[7:10]};
      case (op)
         3'd0: r[rx] = imm;
         3'd1: r[rx] = r[ry];
         3'd2: r[rx] = r[rx] + r[ry];
         3'd3: r[rx] = r[rx] - r[ry];
         3'd5: r[rx] = r[rx] + imm;
         3'd6: r[rx] = r[rx] - imm;
         default: ;
      endcase
   endtask

   task automatic write_word(input int a, input logic [0:INSTR_W-1] d);
      prog_we = 1'b1; prog_addr = ADDR_W'(a); prog_data = d;
      @(posedge clk); #1;
      prog_we = 1'b0;
      mem_m[a] = d;
   endtask

   // Expected trace: each instruction is hold cycles of exec then one gap,
   // then a done cycle, then idle with pc/instr held.
   task automatic build_run(input int len, input int last_ord);
      int n, k;
      n = (len > DEPTH) ? DEPTH : len;
      exp_q.delete(); ord_q.delete();
      if (n == 0) begin
         exp_q.push_back('{1'b0, 1'b0, 1'b1, last_instr_m, last_pc_m}); ord_q.push_back(-1);
      end else begin
         for (k = 0; k <= last_ord; k++) begin
            for (int h = 0; h < hold_of(mem_m[k % n]); h++) begin
               exp_q.push_back('{1'b1, 1'b1, 1'b0, mem_m[k % n], ADDR_W'(k % n)}); ord_q.push_back(k);
            end
            exp_q.push_back('{1'b0, 1'b1, 1'b0, mem_m[k % n], ADDR_W'(k % n)}); ord_q.push_back(k);
         end
         last_instr_m = mem_m[last_ord % n];
         last_pc_m    = ADDR_W'(last_ord % n);
         exp_q.push_back('{1'b0, 1'b0, 1'b1, last_instr_m, last_pc_m}); ord_q.push_back(-1);
      end
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{1'b0, 1'b0, 1'b0, last_instr_m, last_pc_m}); ord_q.push_back(-1);
      end
   endtask

   // stop_ord < 0 means no stop; poke drives start/prog_we during the busy phase.
   task automatic do_run(input int len, input int stop_ord, input bit poke,
                         input bit we0, input logic [0:INSTR_W-1] we0_data);
      int n, last_ord, stop_cyc;
      int cands[$];
      rec_t act;
      n = (len > DEPTH) ? DEPTH : len;
      if (we0) mem_m[0] = we0_data;
`ifdef SEQ_LOOP_EN
      if (stop_ord < 0) stop_ord = (n > 0) ? n - 1 : 0;
      last_ord = stop_ord;
`else
      last_ord = (stop_ord >= 0 && stop_ord < n - 1) ? stop_ord : n - 1;
`endif
      build_run(len, last_ord);
      stop_cyc = -1;
      if (stop_ord >= 0 && n > 0) begin
         for (int i = 0; i < exp_q.size(); i++) if (ord_q[i] == stop_ord) cands.push_back(i);
         if (cands.size() > 0) stop_cyc = cands[$urandom_range(cands.size() - 1)];
      end
      prog_len = (ADDR_W+1)'(len);
      start = 1'b1;
      if (we0) begin prog_we = 1'b1; prog_addr = '0; prog_data = we0_data; end
      for (int c = 0; c < exp_q.size(); c++) begin
         @(posedge clk); #1;
         start = 1'b0; prog_we = 1'b0; stop = 1'b0;
         act = '{exec, busy, done, instr, pc};
         checks++;
         if (act !== exp_q[c]) begin
            errors++;
            $display("FAIL trace[%0d] len=%0d: got ex=%b bz=%b dn=%b ins=%b pc=%0d, want ex=%b bz=%b dn=%b ins=%b pc=%0d",
                     c, len, act.ex, act.bz, act.dn, act.ins, act.p,
                     exp_q[c].ex, exp_q[c].bz, exp_q[c].dn, exp_q[c].ins, exp_q[c].p);
         end
         if (exec && !exec_prev) sm_exec(instr);
         exec_prev = exec;
         stop = (c == stop_cyc);
         if (poke && exp_q[c].bz && (c % 3 == 1)) begin
            start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = ~mem_m[0];
         end
      end
      stop = 1'b0; start = 1'b0; prog_we = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({exec, busy, done, instr, pc} !== '0) begin
         errors++;
         $display("FAIL reset_state: got ex=%b bz=%b dn=%b ins=%b pc=%0d, want all 0", exec, busy, done, instr, pc);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) write_word(i, 11'b10100000011);
      prog_len = 5'd4; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({exec, busy, done, instr, pc} !== '0) begin
         errors++;
         $display("FAIL reset_mid_issue: got ex=%b bz=%b dn=%b ins=%b pc=%0d, want all 0", exec, busy, done, instr, pc);
      end
      last_instr_m = '0; last_pc_m = '0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_loads();
      logic [0:INSTR_W-1] p [4];
      logic [7:0] want [4];
      p = '{11'b00000000001, 11'b00001000010, 11'b00010000100, 11'b00011001000};
      want = '{8'd1, 8'd2, 8'd4, 8'd8};
      for (int i = 0; i < 4; i++) r[i] = 8'hAA;
      for (int i = 0; i < 4; i++) write_word(i, p[i]);
      do_run(4, -1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (r[i] !== want[i]) begin
            errors++;
            $display("FAIL loads_r%0d: got %0d, want %0d", i, r[i], want[i]);
         end
      end
   endtask

   task automatic test_alu();
      logic [0:INSTR_W-1] p [6];
      p = '{11'b00110110000, 11'b01010010000, 11'b01111000000,
            11'b10111001000, 11'b11011000101, 11'b10011000000};
      for (int i = 0; i < 6; i++) write_word(i, p[i]);
      do_run(6, -1, 1'b0, 1'b0, '0);
      checks++;
      if (r[2] !== 8'd10) begin errors++; $display("FAIL alu_r2: got %0d, want 10", r[2]); end
      checks++;
      if (r[3] !== 8'd10) begin errors++; $display("FAIL alu_r3: got %0d, want 10", r[3]); end
   endtask

   task automatic test_len_zero();
      do_run(0, -1, 1'b0, 1'b0, '0);
   endtask

   task automatic test_stop_busy();
      for (int i = 0; i < 4; i++) write_word(i, 11'($urandom));
      do_run(4, 1, 1'b1, 1'b0, '0);
      do_run(2, -1, 1'b0, 1'b0, '0);
   endtask

   task automatic test_write_first();
      write_word(1, 11'b01000000000);
      do_run(2, -1, 1'b0, 1'b1, 11'b00001001111);
   endtask

   task automatic test_random();
      int len, s;
      for (int it = 0; it < 10; it++) begin
         for (int w = 0; w < 6; w++) write_word($urandom_range(DEPTH - 1), 11'($urandom));
         len = (it == 3) ? 31 : ((it == 5) ? DEPTH : $urandom_range(20));
         s = ($urandom_range(1) == 1) ? $urandom_range(DEPTH) : -1;
         do_run(len, s, 1'($urandom_range(1)), 1'b0, '0);
      end
   endtask

`ifdef SEQ_LOOP_EN
   task automatic test_loop();
      write_word(0, 11'b00000000011);
      write_word(1, 11'b01000000000);
      do_run(2, 6, 1'b0, 1'b0, '0);
   endtask
`endif

   initial begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;
      test_reset();
      test_reset_mid();
      test_loads();
      test_alu();
      test_len_zero();
      test_stop_busy();
      test_write_first();
`ifdef SEQ_LOOP_EN
      test_loop();
`endif
      for (int i = 0; i < DEPTH; i++) write_word(i, 11'($urandom));
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, want completion");
      $fatal(1);
   end
endmodule
`default_nettype wire
